bitmap_pair_scheduler: RTL and testbench
========================================

Name: bitmap_pair_scheduler

Overview:
- Sequences the bitmap-compressed sparse matmul datapath (C = A x B, inner-product order).
- Walks A row bitmaps and B column bitmaps pairwise and ANDs each pair to find matching K-indices.
- For each match, emits non-zero-buffer read addresses for A and B to the multiply/accumulate port stage, with valid/ready flow control.
- Sits between the bitmap registers and the non-zero memories/MAC lanes.

Parameters:
- WORD_SIZE, 16, datapath word width (passed through for package consistency).
- ADDR_SIZE, 12, non-zero buffer address width.
- BM_WIDTH, 4, bits per bitmap row/column (K dimension).
- ROW_W, 3, width of row/column counters (max 2^ROW_W-1 rows/cols).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a job; ignored unless idle.
- num_rows_a  in  ROW_W  number of A rows; sampled on start.
- num_cols_b  in  ROW_W  number of B columns; sampled on start.
- nz_base_a  in  ADDR_SIZE  A non-zero buffer base; sampled on start.
- nz_base_b  in  ADDR_SIZE  B non-zero buffer base; sampled on start.
- bm_a_idx  out  ROW_W  A bitmap row select.
- bm_a_row  in  BM_WIDTH  A bitmap row, combinational read of bm_a_idx.
- bm_b_idx  out  ROW_W  B bitmap column select.
- bm_b_col  in  BM_WIDTH  B bitmap column, combinational read of bm_b_idx.
- iss_valid  out  1  issue beat valid.
- iss_ready  in  1  downstream accepts the beat.
- iss_addr_a  out  ADDR_SIZE  A non-zero address.
- iss_addr_b  out  ADDR_SIZE  B non-zero address.
- iss_row  out  ROW_W  output row i.
- iss_col  out  ROW_W  output column j.
- iss_last  out  1  final beat for (i,j).
- iss_zero  out  1  intersection empty; the beat carries no operands and C[i][j]=0.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and bases 0. Reset mid-job aborts immediately. No done pulse is emitted and a pending beat is dropped.
- FSM states: IDLE, LOAD, ISSUE, ADV, DONE.
- IDLE:
  - On start, latch the config and set i=j=0, base_a=nz_base_a, base_b=nz_base_b, busy=1.
  - If either dimension is 0, go to DONE; otherwise go to LOAD.
- LOAD (1 cycle):
  - Drive bm_a_idx=i, bm_b_idx=j.
  - Register rowA, colB and mask = rowA & colB.
  - Go to ISSUE.
- ISSUE:
  - Present one beat per set mask bit, lowest k first.
  - iss_addr_a = base_a + popcount(rowA[k-1:0]); iss_addr_b = base_b + popcount(colB[k-1:0]). Addresses wrap modulo 2^ADDR_SIZE.
  - iss_last is set on the highest set bit.
  - If mask==0, present a single beat with iss_zero=1, iss_last=1 and addresses 0.
  - A beat transfers when iss_valid & iss_ready. While ready is low, every iss_* output holds stable.
  - After the last transfer, go to ADV.
- ADV (1 cycle, iss_valid=0):
  - If j < num_cols_b-1: j++, base_b += popcount(colB), go to LOAD.
  - Else if i < num_rows_a-1: i++, j=0, base_a += popcount(rowA), base_b=nz_base_b, go to LOAD.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Latency: the first beat is valid 2 cycles after start. Per-pair cost is 2 + beats cycles when ready is held high.
- start while busy: ignored. start in the same cycle as DONE: ignored.

Decomposition:
- Shared package bitmap_sched_pkg:
  - state enum;
  - popcount function (BM_WIDTH generic);
  - prefix-count function popcount_below(vec, k).
- One sub-module, lowest_set_bit_picker: given a mask, return the index of the lowest set bit, a last flag (exactly one bit set), and the mask with that bit cleared.

Test Plan:
- Basic 2x2 run. Setup: BM_WIDTH=4, A rows {0011, 0101}, B cols {0001, 0110}, nz_base_a=0, nz_base_b=100, ready held 1.
  - Required beats (row, col, addr_a, addr_b), all last=1: (0,0,0,100), (0,1,1,101), (1,0,2,100), (1,1,3,102).
  - done pulses once after the last beat.
- Multi-beat pair: A row 1111, B col 1011 -> three beats with addr_a 0,1,3, addr_b 100,101,102; iss_last only on the third.
- Empty intersection: A row 1000, B col 0001 -> one beat with iss_zero=1, iss_last=1; then done.
- Backpressure: in the multi-beat case, hold iss_ready=0 for 3 cycles on beat 2 -> outputs stable throughout, no beat lost or duplicated.
- Boundaries:
  - num_rows_a=0 -> done 2 cycles after start, no beats.
  - start while busy -> no effect.
  - Base wrap: nz_base_a=4095 with 2 A non-zeros -> addresses 4095, 0.
- Reset mid-ISSUE: assert rst during beat 1 -> next cycle iss_valid=0, busy=0, done=0. A subsequent start reruns the basic run correctly.

Source files
------------

// File: rtl/bitmap_sched_pkg.sv
// Shared types, sizes and bit-count helpers for the bitmap pair scheduler.
package bitmap_sched_pkg;
  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 12;
  localparam int BM_WIDTH  = 4;
  localparam int ROW_W     = 3;
  localparam int IDX_W     = (BM_WIDTH > 1) ? $clog2(BM_WIDTH) : 1;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [BM_WIDTH-1:0]  bm_t;
  typedef logic [ROW_W-1:0]     rc_t;
  typedef logic [IDX_W-1:0]     idx_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_ADV, S_DONE} state_e;

  function automatic addr_t popcount(input bm_t v);
    addr_t n;
    n = '0;
    for (int b = 0; b < BM_WIDTH; b++) n = n + addr_t'(v[b]);
    return n;
  endfunction

  // Number of set bits strictly below position k: the rank of bit k in the non-zero buffer.
  function automatic addr_t popcount_below(input bm_t v, input idx_t k);
    addr_t n;
    n = '0;
    for (int b = 0; b < BM_WIDTH; b++)
      if (b < int'(k)) n = n + addr_t'(v[b]);
    return n;
  endfunction
endpackage

// File: rtl/bitmap_pair_scheduler_if.sv
// Config, bitmap-read and issue-beat signals of the scheduler; master is the scheduler side.
interface bitmap_pair_scheduler_if;
  import bitmap_sched_pkg::*;

  logic  start;
  rc_t   num_rows_a, num_cols_b;
  addr_t nz_base_a, nz_base_b;
  rc_t   bm_a_idx, bm_b_idx;
  bm_t   bm_a_row, bm_b_col;
  logic  iss_valid, iss_ready;
  addr_t iss_addr_a, iss_addr_b;
  rc_t   iss_row, iss_col;
  logic  iss_last, iss_zero;
  logic  busy, done;

  modport master (
    input  start, num_rows_a, num_cols_b, nz_base_a, nz_base_b, bm_a_row, bm_b_col, iss_ready,
    output bm_a_idx, bm_b_idx, iss_valid, iss_addr_a, iss_addr_b, iss_row, iss_col,
           iss_last, iss_zero, busy, done
  );

  modport slave (
    output start, num_rows_a, num_cols_b, nz_base_a, nz_base_b, bm_a_row, bm_b_col, iss_ready,
    input  bm_a_idx, bm_b_idx, iss_valid, iss_addr_a, iss_addr_b, iss_row, iss_col,
           iss_last, iss_zero, busy, done
  );
endinterface

// File: rtl/bitmap_pair_scheduler_lowest_set_bit_picker.sv
// Picks the lowest set bit of a match mask, flags it as the final one, and returns the remainder.
module lowest_set_bit_picker
  import bitmap_sched_pkg::*;
(
  input  bm_t  mask_i,
  output idx_t idx_o,
  output logic last_o,
  output bm_t  rest_o
);
  always_comb begin
    idx_o = '0;
    for (int b = BM_WIDTH - 1; b >= 0; b--)
      if (mask_i[b]) idx_o = idx_t'(b);
  end

  assign rest_o = mask_i & (mask_i - bm_t'(1));
  assign last_o = (mask_i != '0) && (rest_o == '0);
endmodule

// File: rtl/bitmap_pair_scheduler.sv
// Walks (row i of A, column j of B) pairs, ANDs their bitmaps and issues one
// non-zero-buffer address beat per matching K index (or one zero beat per empty pair).
module bitmap_pair_scheduler
  import bitmap_sched_pkg::*;
(
  input logic clk,
  input logic rst,
  bitmap_pair_scheduler_if.master bus
);
  state_e state_q, state_d;
  rc_t    i_q, i_d, j_q, j_d, nrows_q, nrows_d, ncols_q, ncols_d;
  addr_t  base_a_q, base_a_d, base_b_q, base_b_d, base_b0_q, base_b0_d;
  bm_t    row_a_q, row_a_d, col_b_q, col_b_d, mask_q, mask_d;
  logic   done_q, done_d;

  idx_t pick_idx;
  logic pick_last, mask_zero, vld;
  bm_t  pick_rest;

  lowest_set_bit_picker u_pick (
    .mask_i (mask_q),
    .idx_o  (pick_idx),
    .last_o (pick_last),
    .rest_o (pick_rest)
  );

  // mask_q holds the not-yet-issued matches; it is only empty in ISSUE for an empty pair.
  assign mask_zero      = (mask_q == '0);
  assign vld            = (state_q == S_ISSUE);
  assign bus.iss_valid  = vld;
  assign bus.iss_zero   = vld & mask_zero;
  assign bus.iss_last   = vld & (mask_zero | pick_last);
  assign bus.iss_addr_a = (vld && !mask_zero) ? base_a_q + popcount_below(row_a_q, pick_idx) : '0;
  assign bus.iss_addr_b = (vld && !mask_zero) ? base_b_q + popcount_below(col_b_q, pick_idx) : '0;
  assign bus.iss_row    = vld ? i_q : '0;
  assign bus.iss_col    = vld ? j_q : '0;
  assign bus.bm_a_idx   = i_q;
  assign bus.bm_b_idx   = j_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_b0_d = base_b0_q;
    row_a_d   = row_a_q;
    col_b_d   = col_b_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        nrows_d   = bus.num_rows_a;
        ncols_d   = bus.num_cols_b;
        i_d       = '0;
        j_d       = '0;
        base_a_d  = bus.nz_base_a;
        base_b_d  = bus.nz_base_b;
        base_b0_d = bus.nz_base_b;
        state_d   = (bus.num_rows_a == '0 || bus.num_cols_b == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        row_a_d = bus.bm_a_row;
        col_b_d = bus.bm_b_col;
        mask_d  = bus.bm_a_row & bus.bm_b_col;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (bus.iss_ready) begin
        mask_d = pick_rest;
        if (mask_zero || pick_last) state_d = S_ADV;
      end
      S_ADV: begin
        if (j_q != ncols_q - rc_t'(1)) begin
          j_d      = j_q + rc_t'(1);
          base_b_d = base_b_q + popcount(col_b_q);
          state_d  = S_LOAD;
        end else if (i_q != nrows_q - rc_t'(1)) begin
          i_d      = i_q + rc_t'(1);
          j_d      = '0;
          base_a_d = base_a_q + popcount(row_a_q);
          base_b_d = base_b0_q;
          state_d  = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      nrows_q   <= '0;
      ncols_q   <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_b0_q <= '0;
      row_a_q   <= '0;
      col_b_q   <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      nrows_q   <= nrows_d;
      ncols_q   <= ncols_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      base_b0_q <= base_b0_d;
      row_a_q   <= row_a_d;
      col_b_q   <= col_b_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_bitmap_pair_scheduler.sv
// Self-checking bench: beats compared against a rank-based model of the sparse inner-product walk.
module tb_bitmap_pair_scheduler;
  import bitmap_sched_pkg::*;

  typedef struct packed {
    rc_t   row;
    rc_t   col;
    addr_t addr_a;
    addr_t addr_b;
    logic  last;
    logic  zero;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   rdy_mode = 0, acc_cnt = 0, hold_cnt = 0, done_cnt = 0;
  bm_t  a_rows [0:7];
  bm_t  b_cols [0:7];
  beat_t exp_q [$];

  bitmap_pair_scheduler_if bus ();

  bitmap_pair_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.bm_a_row = a_rows[bus.bm_a_idx];
  assign bus.bm_b_col = b_cols[bus.bm_b_idx];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address of a non-zero = base + number of non-zeros stored before it (earlier rows/cols, then lower k).
  task automatic build_exp(input int nr, input int nc, input int ba, input int bb);
    exp_q.delete();
    for (int i = 0; i < nr; i++)
      for (int j = 0; j < nc; j++) begin
        int  offa, offb;
        bm_t m;
        beat_t b;
        offa = ba;
        offb = bb;
        for (int r = 0; r < i; r++) offa += $countones(a_rows[r]);
        for (int c = 0; c < j; c++) offb += $countones(b_cols[c]);
        m = a_rows[i] & b_cols[j];
        if (m == '0) begin
          b = '{row: rc_t'(i), col: rc_t'(j), addr_a: '0, addr_b: '0, last: 1'b1, zero: 1'b1};
          exp_q.push_back(b);
        end else begin
          for (int k = 0; k < BM_WIDTH; k++)
            if (m[k]) begin
              bm_t below;
              below = bm_t'((1 << k) - 1);
              b.row    = rc_t'(i);
              b.col    = rc_t'(j);
              b.addr_a = addr_t'(offa + $countones(a_rows[i] & below));
              b.addr_b = addr_t'(offb + $countones(b_cols[j] & below));
              b.last   = ((int'(m) >> (k + 1)) == 0);
              b.zero   = 1'b0;
              exp_q.push_back(b);
            end
        end
      end
  endtask

  initial begin
    bus.iss_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.iss_ready = 1'b1;
        1: bus.iss_ready = ($urandom_range(0, 3) != 0);
        2: if (acc_cnt == 1 && hold_cnt < 3) begin
             bus.iss_ready = 1'b0;
             hold_cnt++;
           end else bus.iss_ready = 1'b1;
        default: bus.iss_ready = 1'b0;
      endcase
    end
  end

  beat_t prev_b;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{row: bus.iss_row, col: bus.iss_col, addr_a: bus.iss_addr_a, addr_b: bus.iss_addr_b,
            last: bus.iss_last, zero: bus.iss_zero};
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", bus.iss_valid, 1);
        chk("hold_beat", cur, prev_b);
      end
      if (bus.iss_valid && bus.iss_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        acc_cnt++;
      end
      prev_stall = bus.iss_valid && !bus.iss_ready;
      prev_b     = cur;
      if (bus.done) done_cnt++;
    end
  end

  task automatic run_job(input int nr, input int nc, input int ba, input int bb,
                         input int mode, input bit poke);
    int lat, first;
    build_exp(nr, nc, ba, bb);
    rdy_mode = mode;
    acc_cnt  = 0;
    hold_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    bus.num_rows_a = rc_t'(nr);
    bus.num_cols_b = rc_t'(nc);
    bus.nz_base_a  = addr_t'(ba);
    bus.nz_base_b  = addr_t'(bb);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat   = 0;
    first = -1;
    while (!bus.done && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_run", bus.busy, 1);
      if (first < 0 && bus.iss_valid) first = lat;
      if (poke && lat == 3) begin
        bus.num_rows_a = '0;
        bus.start      = 1'b1;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("done_seen", bus.done, 1);
    if (nr == 0 || nc == 0) begin
      chk("done_lat", lat, 2);
      chk("no_beat", first, -1);
    end else chk("first_lat", first, 2);
    @(negedge clk);
    @(negedge clk);
    chk("beats_left", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after", bus.busy, 0);
  endtask

  task automatic load_basic();
    a_rows[0] = 4'b0011; a_rows[1] = 4'b0101;
    b_cols[0] = 4'b0001; b_cols[1] = 4'b0110;
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    bus.num_rows_a = '0;
    bus.num_cols_b = '0;
    bus.nz_base_a = '0;
    bus.nz_base_b = '0;
    for (int k = 0; k < 8; k++) begin a_rows[k] = '0; b_cols[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.iss_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_addr", {bus.iss_addr_a, bus.iss_addr_b}, 0);
    chk("rst_idx", {bus.bm_a_idx, bus.bm_b_idx}, 0);
    rst = 1'b0;

    load_basic();
    run_job(2, 2, 0, 100, 0, 1'b0);
    a_rows[0] = 4'b1111; b_cols[0] = 4'b1011;
    run_job(1, 1, 0, 100, 0, 1'b0);
    run_job(1, 1, 0, 100, 2, 1'b0);
    chk("stall_cycles", hold_cnt, 3);
    a_rows[0] = 4'b1000; b_cols[0] = 4'b0001;
    run_job(1, 1, 0, 100, 0, 1'b0);
    run_job(0, 3, 7, 9, 0, 1'b0);
    run_job(2, 0, 7, 9, 0, 1'b0);
    load_basic();
    run_job(2, 2, 0, 100, 1, 1'b1);
    a_rows[0] = 4'b0011; b_cols[0] = 4'b0011;
    run_job(1, 1, 4095, 4094, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 8; k++) begin
        a_rows[k] = bm_t'($urandom);
        b_cols[k] = bm_t'($urandom);
      end
      run_job($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 1), 1'b0);
    end

    // Abort a job while its first beat is pending, then rerun the basic case.
    load_basic();
    build_exp(2, 2, 0, 100);
    rdy_mode = 3;
    @(posedge clk);
    #1;
    bus.num_rows_a = 3'd2; bus.num_cols_b = 3'd2;
    bus.nz_base_a = 12'd0; bus.nz_base_b = 12'd100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t = 0;
    while (!bus.iss_valid && t < 20) begin @(negedge clk); t++; end
    chk("abort_beat_up", bus.iss_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", bus.iss_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_job(2, 2, 0, 100, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
